// File: rtl/key_event.sv
// key_event: per-button event generator downstream of the debounce stage.
//
// Turns one debounced, clock-synchronous key level into single-cycle event
// pulses (press, release, click, long press, auto-repeat), a held level and
// a wrapping press counter. Every output is driven straight from a flop.
//
// Parameters
//   LONG_CYC     cycles the key must stay down before long_press fires (>= 2)
//   REP_CYC      auto-repeat period once long_press has fired (>= 1)
//   CNT_W        hold-counter width, must hold max(LONG_CYC, REP_CYC) - 1
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   key          debounced key level, 1 = pressed, synchronous to clk
//   en           event enable, 0 locks the block out
//   press        one-cycle pulse when a press is accepted
//   release_evt  one-cycle pulse on release from DOWN or REPEAT
//                (the bare name "release" is a reserved word)
//   click        one-cycle pulse on a release that came before long_press
//   long_press   one-cycle pulse when the hold reaches LONG_CYC cycles
//   rpt          one-cycle auto-repeat pulse every REP_CYC cycles after that
//   held         level, 1 while in DOWN or REPEAT
//   press_cnt    count of press pulses, wraps 255 -> 0
module key_event #(
    parameter int LONG_CYC = 50_000_000,
    parameter int REP_CYC  = 10_000_000,
    parameter int CNT_W    = 27
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key,
    input  logic       en,
    output logic       press,
    output logic       release_evt,
    output logic       click,
    output logic       long_press,
    output logic       rpt,
    output logic       held,
    output logic [7:0] press_cnt
);

    localparam logic [1:0] LOCK   = 2'd0;
    localparam logic [1:0] IDLE   = 2'd1;
    localparam logic [1:0] DOWN   = 2'd2;
    localparam logic [1:0] REPEAT = 2'd3;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             held_q, held_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    // Priority: en=0 lockout, then key release, then counter terminal events.
    // Release beats a coinciding terminal count, so no long_press/rpt then.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        click_d     = 1'b0;
        long_d      = 1'b0;
        rpt_d       = 1'b0;
        press_cnt_d = press_cnt_q;
        if (!en) begin
            // Lockout mid-hold is silent: no release or click is reported.
            state_d = LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                // A key held through reset or lockout must go low before it
                // can produce a press.
                LOCK: if (!key) state_d = IDLE;
                IDLE: begin
                    if (key) begin
                        state_d     = DOWN;
                        cnt_d       = '0;
                        press_d     = 1'b1;
                        press_cnt_d = press_cnt_q + 8'd1;
                    end
                end
                DOWN: begin
                    if (!key) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                        click_d   = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!key) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = LOCK;
            endcase
        end
        // held follows the state being entered so it rises with press.
        held_d = (state_d == DOWN) || (state_d == REPEAT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= LOCK;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            click_q     <= 1'b0;
            long_q      <= 1'b0;
            rpt_q       <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            click_q     <= click_d;
            long_q      <= long_d;
            rpt_q       <= rpt_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press       = press_q;
    assign release_evt = release_q;
    assign click       = click_q;
    assign long_press  = long_q;
    assign rpt         = rpt_q;
    assign held        = held_q;
    assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed checks of key_event with short hold timings.
module tb_key_event;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       key  = 1'b0;
    logic       en   = 1'b1;
    logic       press, rel, click, long_press, rpt, held;
    logic [7:0] press_cnt;
    logic       p2, r2, c2, l2, t2, h2;
    logic [7:0] pc2;
    logic [5:0] o, o2;
    int         vec  = 0;
    int         errs = 0;

    // Output vector order: press, release, click, long_press, rpt, held.
    assign o  = {press, rel, click, long_press, rpt, held};
    assign o2 = {p2, r2, c2, l2, t2, h2};

    key_event #(.LONG_CYC(8), .REP_CYC(4), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .key(key), .en(en),
        .press(press), .release_evt(rel), .click(click),
        .long_press(long_press), .rpt(rpt), .held(held), .press_cnt(press_cnt)
    );

    // Smallest legal timing: LONG_CYC=2, REP_CYC=1.
    key_event #(.LONG_CYC(2), .REP_CYC(1), .CNT_W(1)) dut2 (
        .clk(clk), .rstn(rstn), .key(key), .en(en),
        .press(p2), .release_evt(r2), .click(c2),
        .long_press(l2), .rpt(t2), .held(h2), .press_cnt(pc2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        key  = 1'b0;
        en   = 1'b1;
        rstn = 1'b0;
        #3;
        vec++;
        if (o !== 6'b000000 || press_cnt !== 8'd0) begin
            errs++;
            $display("FAIL reset: outs=%b cnt=%0d required 000000/0", o, press_cnt);
        end
        tick();
        rstn = 1'b1;
        tick();
        tick();
        vec++;
        if (o !== 6'b000000) begin
            errs++;
            $display("FAIL reset_idle: outs=%b required 000000", o);
        end
    endtask

    task automatic test_short();
        key = 1'b1;
        tick();
        vec++;
        if (o !== 6'b100001 || press_cnt !== 8'd1) begin
            errs++;
            $display("FAIL short_press: outs=%b cnt=%0d required 100001/1", o, press_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (o !== 6'b000001) begin
                errs++;
                $display("FAIL short_hold[%0d]: outs=%b required 000001", i, o);
            end
        end
        key = 1'b0;
        tick();
        vec++;
        if (o !== 6'b011000) begin
            errs++;
            $display("FAIL short_release: outs=%b required 011000", o);
        end
        tick();
        vec++;
        if (o !== 6'b000000 || press_cnt !== 8'd1) begin
            errs++;
            $display("FAIL short_after: outs=%b cnt=%0d required 000000/1", o, press_cnt);
        end
    endtask

    task automatic test_long();
        logic [5:0] exp;
        key = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = {i == 0, 1'b0, 1'b0, i == 8, i == 12 || i == 16, 1'b1};
            vec++;
            if (o !== exp) begin
                errs++;
                $display("FAIL long_hold[%0d]: outs=%b required %b", i, o, exp);
            end
        end
        key = 1'b0;
        tick();
        vec++;
        if (o !== 6'b010000 || press_cnt !== 8'd2) begin
            errs++;
            $display("FAIL long_release: outs=%b cnt=%0d required 010000/2", o, press_cnt);
        end
        tick();
    endtask

    task automatic test_collision();
        logic [5:0] exp;
        key = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {i == 0, 5'b00001};
            vec++;
            if (o !== exp) begin
                errs++;
                $display("FAIL coll_hold[%0d]: outs=%b required %b", i, o, exp);
            end
        end
        key = 1'b0;
        tick();
        vec++;
        if (o !== 6'b011000) begin
            errs++;
            $display("FAIL coll_release: outs=%b required 011000", o);
        end
        tick();
        vec++;
        if (o !== 6'b000000 || press_cnt !== 8'd3) begin
            errs++;
            $display("FAIL coll_after: outs=%b cnt=%0d required 000000/3", o, press_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            key = (i % 2 == 0);
            tick();
            vec++;
            if (o !== (key ? 6'b100001 : 6'b011000)) begin
                errs++;
                $display("FAIL b2b[%0d]: outs=%b required %b", i, o, key ? 6'b100001 : 6'b011000);
            end
        end
        vec++;
        if (press_cnt !== 8'd5) begin
            errs++;
            $display("FAIL b2b_cnt: cnt=%0d required 5", press_cnt);
        end
        tick();
    endtask

    task automatic test_lock_reset();
        key = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
        #1;
        vec++;
        if (o !== 6'b000000 || press_cnt !== 8'd0) begin
            errs++;
            $display("FAIL lock_async: outs=%b cnt=%0d required 000000/0", o, press_cnt);
        end
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (o !== 6'b000000) begin
                errs++;
                $display("FAIL lock_held[%0d]: outs=%b required 000000", i, o);
            end
        end
        key = 1'b0;
        tick();
        key = 1'b1;
        tick();
        vec++;
        if (o !== 6'b100001 || press_cnt !== 8'd1) begin
            errs++;
            $display("FAIL lock_repress: outs=%b cnt=%0d required 100001/1", o, press_cnt);
        end
    endtask

    task automatic test_en_drop();
        tick();
        en = 1'b0;
        tick();
        vec++;
        if (o !== 6'b000000) begin
            errs++;
            $display("FAIL en_drop: outs=%b required 000000", o);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++;
            if (o !== 6'b000000 || press_cnt !== 8'd1) begin
                errs++;
                $display("FAIL en_held[%0d]: outs=%b cnt=%0d required 000000/1", i, o, press_cnt);
            end
        end
        key = 1'b0;
        tick();
        key = 1'b1;
        tick();
        vec++;
        if (o !== 6'b100001 || press_cnt !== 8'd2) begin
            errs++;
            $display("FAIL en_repress: outs=%b cnt=%0d required 100001/2", o, press_cnt);
        end
        key = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        int n;
        n    = 0;
        key  = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            key = 1'b1;
            tick();
            if (press === 1'b1) n++;
            key = 1'b0;
            tick();
            if (i == 254) begin
                vec++;
                if (press_cnt !== 8'd255) begin
                    errs++;
                    $display("FAIL wrap_255: cnt=%0d required 255", press_cnt);
                end
            end
        end
        vec++;
        if (press_cnt !== 8'd0 || n != 256) begin
            errs++;
            $display("FAIL wrap: cnt=%0d pulses=%0d required 0/256", press_cnt, n);
        end
    endtask

    task automatic test_rep1();
        logic [5:0] exp;
        key  = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        key = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = {i == 0, 1'b0, 1'b0, i == 2, i >= 3, 1'b1};
            vec++;
            if (o2 !== exp) begin
                errs++;
                $display("FAIL rep1[%0d]: outs=%b required %b", i, o2, exp);
            end
        end
        key = 1'b0;
        tick();
        vec++;
        if (o2 !== 6'b010000) begin
            errs++;
            $display("FAIL rep1_release: outs=%b required 010000", o2);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_collision();
        test_back_to_back();
        test_lock_reset();
        test_en_drop();
        test_wrap();
        test_rep1();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/key_event.md
# key_event

Per-button event generator downstream of the debounce stage. It takes one debounced, clock-synchronous key level and turns it into single-cycle event pulses for the control FSMs: press, release, short click, long press and auto-repeat. It also provides a held level and a wrapping press counter. All outputs are registered.

## Interface
- LONG_CYC, 50_000_000: cycles the key must stay down before long_press fires; legal range ≥ 2.
- REP_CYC, 10_000_000: auto-repeat period after long_press; legal range ≥ 1.
- CNT_W, 27: hold-counter width; must hold max(LONG_CYC, REP_CYC) − 1.
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- key  in  1  debounced key level, 1 = pressed, synchronous to clk.
- en  in  1  event enable; 0 = block locked out.
- press  out  1  one-cycle pulse on press.
- release  out  1  one-cycle pulse on release from DOWN or REPEAT.
- click  out  1  one-cycle pulse on release before long_press (short press).
- long_press  out  1  one-cycle pulse when the hold reaches LONG_CYC.
- rpt  out  1  one-cycle auto-repeat pulse.
- held  out  1  level, 1 while in DOWN or REPEAT.
- press_cnt  out  8  count of press pulses; wraps 255 → 0.

## Operation
- States: LOCK, IDLE, DOWN, REPEAT. Reset state is LOCK.
- Hold counter cnt (CNT_W bits) is internal; it resets to 0.
- Priority, evaluated every edge: en=0 first, then key=0 release, then counter events.
- Any state with en=0: next state LOCK, cnt←0, no pulses, held←0.
  - This applies even mid-hold. An en drop while held produces no release or click.
- LOCK, en=1, key=0: go to IDLE.
- LOCK, en=1, key=1: stay in LOCK. A key held through reset or through the lockout never produces a press.
- IDLE, key=1: go to DOWN, cnt←0, press←1, press_cnt←press_cnt+1.
- DOWN, key=1:
  - cnt = LONG_CYC−1: go to REPEAT, cnt←0, long_press←1.
  - Otherwise: cnt←cnt+1.
- DOWN, key=0: go to IDLE, cnt←0, release←1, click←1.
- REPEAT, key=1:
  - cnt = REP_CYC−1: cnt←0, rpt←1.
  - Otherwise: cnt←cnt+1.
- REPEAT, key=0: go to IDLE, cnt←0, release←1, click stays 0.
- Simultaneous key=0 and counter terminal in the same cycle: the release wins, with no long_press or rpt.
- Pulse outputs default to 0 every cycle; each is high for exactly one cycle per event.
- press and release are never high in the same cycle.

## Timing
- Reset values: state LOCK, cnt 0. press, release, click, long_press, rpt and held are 0. press_cnt is 0.
- Key sampled 1 in IDLE at edge k:
  - press and held are high after edge k.
  - press_cnt is incremented after edge k.
- Key stays 1:
  - long_press is high after edge k+LONG_CYC.
  - First rpt is high after edge k+LONG_CYC+REP_CYC, then after every further REP_CYC edges.
  - REP_CYC=1 gives rpt high every cycle in REPEAT.
- Key sampled 0 at edge m while in DOWN or REPEAT: release is high and held is 0 after edge m. click is also high if the state was DOWN.
- Minimum press → next press spacing: 2 cycles, via key 1,0,1 on consecutive edges.
- rstn assertion mid-hold: all outputs clear immediately (asynchronous). Key must return to 0 with en=1 before the next press.

## Test plan
- Short press, with LONG_CYC=8, REP_CYC=4, en=1, key high for 5 cycles:
  - press once, 1 cycle after key rises.
  - release and click 1 cycle after key falls.
  - no long_press; press_cnt=1.
- Long hold, key high for 20 cycles:
  - long_press at press+8.
  - rpt at press+12 and press+16.
  - release with click=0; held high for exactly 20 cycles.
- Release colliding with the long_press terminal: key falls on edge k+8.
  - release and click high; long_press never fires.
- Lockout:
  - Key held high through reset deassertion: no press until key goes low and high again.
  - en dropped mid-hold: held falls to 0, no release; key still high after en returns → no press.
- Counter wrap: 256 short presses → press_cnt returns to 0, and 256 press pulses are counted.
- Back-to-back key 1,0,1: two press pulses 2 cycles apart and one release/click between them.
